rgb565_grey_bram_loader: RTL and testbench
==========================================

# rgb565_grey_bram_loader

Streams RGB565 pixel pairs from a 32-bit read FIFO, converts each pixel to 8-bit grey, and writes the result into a 32-bit-wide BRAM at consecutive word addresses from a programmable base. Runs one frame per `start` pulse and reports completion. It sits between the pixel-capture FIFO and the frame BRAM read by the display and disparity logic. It supersedes the fixed-function loader with frame control, configurable packing and grey modes, and correct FIFO read latency.

## Interface
- `ADDR_W`, 32, width of the BRAM word address.
- `FRAME_WORDS`, 38400, FIFO words per frame (2 pixels each). Must be ≥1, and even when `PACK`=1.
- `PACK`, 0, output format: 0 = one BRAM word per FIFO word; 1 = one BRAM word per two FIFO words.
- `GREY_MODE`, 0, conversion: 0 = average, 1 = luma weights.
- `clk`  in  1  clock.
- `rst`  in  1  reset: synchronous, active-high, on `clk`.
- `start`  in  1  one-cycle frame start; ignored while `busy`=1.
- `abort`  in  1  cancels the current frame; no effect when idle.
- `base_addr`  in  ADDR_W  first BRAM word address, sampled on accepted `start`.
- `fifo_rd_en`  out  1  FIFO read strobe (combinational).
- `fifo_dout`  in  32  FIFO data, valid the cycle after a read. Bits [15:0] hold the earlier pixel.
- `fifo_empty`  in  1  FIFO empty flag.
- `bram_clk`  out  1  equals `clk`.
- `bram_en`  out  1  BRAM write enable strobe.
- `bram_we`  out  4  byte write enables: 4'hF when `bram_en`=1, else 4'h0.
- `bram_addr`  out  ADDR_W  BRAM word address.
- `bram_din`  out  32  BRAM write data.
- `busy`  out  1  frame in progress.
- `frame_done`  out  1  one-cycle pulse when a frame completes.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE → RUN on `start`.
  - RUN → DONE after the final BRAM write.
  - DONE → IDLE after one cycle.
  - `abort` in RUN → IDLE.
- `fifo_rd_en` = RUN && !`fifo_empty` && (reads issued < `FRAME_WORDS`). No more than `FRAME_WORDS` reads are issued per frame.
- Pixel decode:
  - r5 = p[15:11], g6 = p[10:5], b5 = p[4:0].
  - Expand by bit replication: r8 = {r5, r5[4:2]}, g8 = {g6, g6[5:4]}, b8 = {b5, b5[4:2]}.
- Grey value:
  - `GREY_MODE`=0: floor((r8+g8+b8)/3). This must be exact for all sums 0..765.
  - `GREY_MODE`=1: (77·r8 + 150·g8 + 29·b8) >> 8, using 16-bit intermediates with no overflow.
- For each FIFO word, g_lo is the grey of [15:0] and g_hi is the grey of [31:16].
- `PACK`=0: `bram_din` = {8'h00, g_hi, 8'h00, g_lo}. One write per FIFO word.
- `PACK`=1: the first word of each pair is held. The second word completes the write with `bram_din` = {g_hi(2nd), g_lo(2nd), g_hi(1st), g_lo(1st)}.
- Addressing:
  - The n-th BRAM write of a frame uses `bram_addr` = `base_addr` + n, mod 2^ADDR_W (wraps).
  - A frame produces `FRAME_WORDS` writes when `PACK`=0, and `FRAME_WORDS`/2 writes when `PACK`=1.
- `busy` = RUN or DONE. `frame_done` = DONE.
- `abort`:
  - Returns to IDLE on the next edge.
  - Discards any in-flight FIFO data and any held half-pair.
  - Produces no further writes and no `frame_done`.
  - `abort` and `start` in the same IDLE cycle: `start` wins.

## Timing
- All outputs are registered except `fifo_rd_en` and `bram_clk`.
- Reset values:
  - All registered outputs are 0, including `bram_we`=4'h0 and `bram_addr`=0.
  - State is IDLE.
  - Counters and the held half-pair are cleared.
- `rst` mid-frame aborts with no further write.
- `start` sampled at edge E sets `busy`=1 after E. `fifo_rd_en` may assert in the first cycle after E.
- A read accepted at edge N (`fifo_rd_en`=1) provides `fifo_dout` valid between N and N+1. It is captured at N+1.
- The resulting write (`PACK`=0), or the pair-completing write (`PACK`=1), is on `bram_en`/`bram_addr`/`bram_din` between N+2 and N+3.
- Throughput is one FIFO word per cycle. An empty FIFO inserts bubbles; writes and addresses stay contiguous.
- `bram_en` is high for exactly one cycle per write.
- `frame_done` is high in the cycle immediately after the final write cycle. `busy` falls after that cycle.
- A `start` in the `frame_done` cycle is ignored.

## Test plan
- Reset: assert `rst` for 2 cycles mid-frame → every registered output is 0, no `bram_en`, and `busy`=0 on the next cycle.
- `PACK`=0, `GREY_MODE`=0, `FRAME_WORDS`=4, `base_addr`=0x100, FIFO words 0xFFFF0000, 0x0000F800, 0x07E0001F, 0xFFFFFFFF → writes 0x00FF0000@0x100, 0x00000055@0x101, 0x00550055@0x102, 0x00FF00FF@0x103. Then one `frame_done` pulse; write latency is N+2.
- `PACK`=1, `GREY_MODE`=0, `FRAME_WORDS`=2, FIFO words 0x07E0F800, 0x001FFFFF → single write 0x55FF5555@`base_addr`.
- `GREY_MODE`=1: pixel 0xF800 → grey 0x4C; 0x07E0 → 0x95; 0xFFFF → 0xFF.
- `fifo_empty` toggled pseudo-randomly, plus `start` pulsed while busy → data and addresses are identical to the unstalled run, exactly `FRAME_WORDS` reads are issued, and the extra `start` has no effect.
- `PACK`=0, `base_addr`=0xFFFFFFFE, `FRAME_WORDS`=4 → addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
- `PACK`=1, `abort` after 1 FIFO word → no write and no `frame_done`, `busy`=0 next cycle. A following `start` runs a clean frame.

Source files
------------

// File: rtl/rgb565_grey_bram_loader.sv
// rgb565_grey_bram_loader
// Streams RGB565 pixel pairs from a 32-bit read FIFO, converts each pixel to
// 8-bit grey and writes the results into a 32-bit BRAM at consecutive word
// addresses starting from a base sampled on start. One frame per start pulse.
//
// Pipeline (read accepted at edge N):
//   N   : rd_vld_q set, FIFO presents data during N..N+1
//   N+1 : raw FIFO word captured into cap_q
//   N+2 : grey values computed from cap_q and registered onto the BRAM port
module rgb565_grey_bram_loader #(
    parameter int ADDR_W      = 32,
    parameter int FRAME_WORDS = 38400,
    parameter int PACK        = 0,
    parameter int GREY_MODE   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              fifo_rd_en,
    input  logic [31:0]       fifo_dout,
    input  logic              fifo_empty,
    output logic              bram_clk,
    output logic              bram_en,
    output logic [3:0]        bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [31:0]       bram_din,
    output logic              busy,
    output logic              frame_done
);

    // Writes per frame: packed mode merges two FIFO words into one BRAM word.
    localparam int TOTAL_WR = (PACK != 0) ? (FRAME_WORDS / 2) : FRAME_WORDS;
    localparam int CNT_W    = $clog2(FRAME_WORDS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    // Convert one RGB565 pixel to 8-bit grey.
    // The average divides by 3 as (sum * 683) >> 11: the reciprocal error is
    // below 0.125 over 0..765, so the floor is exact for every input.
    function automatic logic [7:0] grey_of(input logic [15:0] p);
        logic [7:0]  r8;
        logic [7:0]  g8;
        logic [7:0]  b8;
        logic [9:0]  sum;
        logic [19:0] prod;
        logic [15:0] wsum;
        r8   = {p[15:11], p[15:13]};
        g8   = {p[10:5], p[10:9]};
        b8   = {p[4:0], p[4:2]};
        sum  = {2'b00, r8} + {2'b00, g8} + {2'b00, b8};
        prod = {10'd0, sum} * 20'd683;
        // Luma weights sum to 256, so the largest total (65280) fits 16 bits.
        wsum = 16'd77 * {8'd0, r8} + 16'd150 * {8'd0, g8} + 16'd29 * {8'd0, b8};
        if (GREY_MODE == 1) begin
            grey_of = 8'(wsum >> 8);
        end else begin
            grey_of = 8'(prod >> 11);
        end
    endfunction

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic              rd_vld_q, rd_vld_d;
    logic              cap_vld_q, cap_vld_d;
    logic [31:0]       cap_q, cap_d;
    logic              half_vld_q, half_vld_d;
    logic [15:0]       half_q, half_d;
    logic [ADDR_W-1:0] next_addr_q, next_addr_d;
    logic              wr_last_q, wr_last_d;
    logic              bram_en_q, bram_en_d;
    logic [3:0]        bram_we_q, bram_we_d;
    logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
    logic [31:0]       bram_din_q, bram_din_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;

    logic [7:0]        g_lo;
    logic [7:0]        g_hi;
    logic              wr_fire;
    logic [31:0]       wr_data;

    assign bram_clk   = clk;
    assign bram_en    = bram_en_q;
    assign bram_we    = bram_we_q;
    assign bram_addr  = bram_addr_q;
    assign bram_din   = bram_din_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

    // Next-state logic: frame control, read issue, capture, grey packing.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; a missing default here would infer a latch.
        state_d      = state_q;
        rd_cnt_d     = rd_cnt_q;
        wr_cnt_d     = wr_cnt_q;
        rd_vld_d     = 1'b0;
        cap_vld_d    = 1'b0;
        cap_d        = cap_q;
        half_vld_d   = half_vld_q;
        half_d       = half_q;
        next_addr_d  = next_addr_q;
        wr_last_d    = 1'b0;
        bram_en_d    = 1'b0;
        bram_we_d    = 4'h0;
        bram_addr_d  = bram_addr_q;
        bram_din_d   = bram_din_q;
        wr_fire      = 1'b0;
        wr_data      = 32'h0;

        g_lo = grey_of(cap_q[15:0]);
        g_hi = grey_of(cap_q[31:16]);

        // Reads stop once the frame's quota has been issued.
        fifo_rd_en = (state_q == S_RUN) && !fifo_empty &&
                     (rd_cnt_q < CNT_W'(FRAME_WORDS));

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_RUN;
                    next_addr_d = base_addr;
                    rd_cnt_d    = '0;
                    wr_cnt_d    = '0;
                    half_vld_d  = 1'b0;
                    half_d      = 16'h0;
                end
            end

            S_RUN: begin
                if (abort) begin
                    // In-flight reads, the captured word and any held
                    // half-pair are dropped; no write is registered.
                    state_d    = S_IDLE;
                    half_vld_d = 1'b0;
                    half_d     = 16'h0;
                end else begin
                    if (fifo_rd_en) begin
                        rd_cnt_d = rd_cnt_q + CNT_W'(1);
                    end
                    rd_vld_d  = fifo_rd_en;
                    cap_vld_d = rd_vld_q;
                    if (rd_vld_q) begin
                        cap_d = fifo_dout;
                    end

                    if (cap_vld_q) begin
                        if (PACK != 0) begin
                            if (half_vld_q) begin
                                wr_fire    = 1'b1;
                                wr_data    = {g_hi, g_lo, half_q};
                                half_vld_d = 1'b0;
                            end else begin
                                half_d     = {g_hi, g_lo};
                                half_vld_d = 1'b1;
                            end
                        end else begin
                            wr_fire = 1'b1;
                            wr_data = {8'h00, g_hi, 8'h00, g_lo};
                        end
                    end

                    if (wr_fire) begin
                        bram_en_d   = 1'b1;
                        bram_we_d   = 4'hF;
                        bram_addr_d = next_addr_q;
                        bram_din_d  = wr_data;
                        next_addr_d = next_addr_q + ADDR_W'(1);
                        wr_cnt_d    = wr_cnt_q + CNT_W'(1);
                        wr_last_d   = (wr_cnt_q == CNT_W'(TOTAL_WR - 1));
                    end

                    // The final write is on the port this cycle; done follows.
                    if (wr_last_q) begin
                        state_d = S_DONE;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d       = (state_d != S_IDLE);
        frame_done_d = (state_d == S_DONE);
    end

    // State and registered outputs, synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples the pre-edge value of the others regardless of order.
        if (rst) begin
            state_q      <= S_IDLE;
            rd_cnt_q     <= '0;
            wr_cnt_q     <= '0;
            rd_vld_q     <= 1'b0;
            cap_vld_q    <= 1'b0;
            cap_q        <= 32'h0;
            half_vld_q   <= 1'b0;
            half_q       <= 16'h0;
            next_addr_q  <= '0;
            wr_last_q    <= 1'b0;
            bram_en_q    <= 1'b0;
            bram_we_q    <= 4'h0;
            bram_addr_q  <= '0;
            bram_din_q   <= 32'h0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_cnt_q     <= rd_cnt_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_vld_q     <= rd_vld_d;
            cap_vld_q    <= cap_vld_d;
            cap_q        <= cap_d;
            half_vld_q   <= half_vld_d;
            half_q       <= half_d;
            next_addr_q  <= next_addr_d;
            wr_last_q    <= wr_last_d;
            bram_en_q    <= bram_en_d;
            bram_we_q    <= bram_we_d;
            bram_addr_q  <= bram_addr_d;
            bram_din_q   <= bram_din_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_rgb565_grey_bram_loader.sv
// Directed bench for rgb565_grey_bram_loader. Three instances cover the
// configurations: 0 = PACK0/average/4 words, 1 = PACK1/average/2 words,
// 2 = PACK0/luma/4 words. A behavioural FIFO feeds each instance and a
// monitor records every BRAM write and frame_done pulse.
module tb_rgb565_grey_bram_loader;

    localparam int NI = 3;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start  [NI];
    logic        abort_s[NI];
    logic [31:0] base   [NI];
    logic        rd_en  [NI];
    logic [31:0] dout   [NI];
    logic        empty  [NI];
    logic        bclk   [NI];
    logic        en     [NI];
    logic [3:0]  we     [NI];
    logic [31:0] addr   [NI];
    logic [31:0] din    [NI];
    logic        busy   [NI];
    logic        done   [NI];

    // FIFO model and monitor state
    logic [31:0] fmem    [NI][DEPTH];
    int          fcnt    [NI];
    int          fptr    [NI];
    int          rd_count[NI];
    int          rcyc    [NI][DEPTH];
    logic        rd_smp  [NI];
    logic        stall   [NI];
    logic        rnd     [NI];
    int          wcnt    [NI];
    logic [31:0] waddr   [NI][DEPTH];
    logic [31:0] wdata   [NI][DEPTH];
    int          wcyc    [NI][DEPTH];
    int          we_bad  [NI];
    int          done_cnt[NI];
    int          done_cyc[NI];
    int          cyc = 0;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    rgb565_grey_bram_loader #(.ADDR_W(32), .FRAME_WORDS(4), .PACK(0), .GREY_MODE(0)) u_p0 (
        .clk(clk), .rst(rst), .start(start[0]), .abort(abort_s[0]), .base_addr(base[0]),
        .fifo_rd_en(rd_en[0]), .fifo_dout(dout[0]), .fifo_empty(empty[0]),
        .bram_clk(bclk[0]), .bram_en(en[0]), .bram_we(we[0]), .bram_addr(addr[0]),
        .bram_din(din[0]), .busy(busy[0]), .frame_done(done[0])
    );

    rgb565_grey_bram_loader #(.ADDR_W(32), .FRAME_WORDS(2), .PACK(1), .GREY_MODE(0)) u_p1 (
        .clk(clk), .rst(rst), .start(start[1]), .abort(abort_s[1]), .base_addr(base[1]),
        .fifo_rd_en(rd_en[1]), .fifo_dout(dout[1]), .fifo_empty(empty[1]),
        .bram_clk(bclk[1]), .bram_en(en[1]), .bram_we(we[1]), .bram_addr(addr[1]),
        .bram_din(din[1]), .busy(busy[1]), .frame_done(done[1])
    );

    rgb565_grey_bram_loader #(.ADDR_W(32), .FRAME_WORDS(4), .PACK(0), .GREY_MODE(1)) u_g1 (
        .clk(clk), .rst(rst), .start(start[2]), .abort(abort_s[2]), .base_addr(base[2]),
        .fifo_rd_en(rd_en[2]), .fifo_dout(dout[2]), .fifo_empty(empty[2]),
        .bram_clk(bclk[2]), .bram_en(en[2]), .bram_we(we[2]), .bram_addr(addr[2]),
        .bram_din(din[2]), .busy(busy[2]), .frame_done(done[2])
    );

    // FIFO empty flag: out of data or stalled this cycle.
    always_comb begin
        for (int i = 0; i < NI; i++) begin
            empty[i] = stall[i] || (fptr[i] >= fcnt[i]);
        end
    end

    // FIFO model: a read sampled before the edge delivers data just after it.
    always @(posedge clk) begin
        cyc++;
        #1;
        for (int i = 0; i < NI; i++) begin
            if (rd_smp[i]) begin
                if (rd_count[i] < DEPTH) rcyc[i][rd_count[i]] = cyc;
                rd_count[i]++;
                dout[i] = (fptr[i] < DEPTH) ? fmem[i][fptr[i]] : 32'hDEAD_BEEF;
                fptr[i]++;
            end
            stall[i] = rnd[i] ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    // Monitor: sample read strobes, BRAM writes and done pulses mid-cycle.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            rd_smp[i] = rd_en[i];
            if (en[i]) begin
                if (wcnt[i] < DEPTH) begin
                    waddr[i][wcnt[i]] = addr[i];
                    wdata[i][wcnt[i]] = din[i];
                    wcyc[i][wcnt[i]]  = cyc;
                end
                if (we[i] !== 4'hF) we_bad[i]++;
                wcnt[i]++;
            end else if (we[i] !== 4'h0) begin
                we_bad[i]++;
            end
            if (done[i]) begin
                done_cnt[i]++;
                done_cyc[i] = cyc;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic model_clear(input int i);
        fcnt[i] = 0;
        fptr[i] = 0;
        rd_count[i] = 0;
        wcnt[i] = 0;
        we_bad[i] = 0;
        done_cnt[i] = 0;
        done_cyc[i] = 0;
        rnd[i] = 1'b0;
        stall[i] = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            waddr[i][k] = 'x;
            wdata[i][k] = 'x;
            wcyc[i][k] = 0;
            rcyc[i][k] = 0;
        end
    endtask

    task automatic load4(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] d, input int n);
        fmem[i][0] = a;
        fmem[i][1] = b;
        fmem[i][2] = c;
        fmem[i][3] = d;
        fcnt[i] = n;
    endtask

    task automatic pulse_start(input int i, input logic [31:0] b);
        base[i] = b;
        start[i] = 1'b1;
        step();
        start[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int budget, input string tag);
        int k = 0;
        while (done_cnt[i] == 0 && k < budget) begin
            step();
            k++;
        end
        n_total++;
        if (done_cnt[i] == 0) $display("FAIL %s_done_timeout: no frame_done within %0d cycles", tag, budget);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_total++;
        if ({en[0], we[0], addr[0], din[0], busy[0], done[0]} !== 70'h0) begin
            $display("FAIL reset_state: en=%b we=%h addr=%h din=%h busy=%b done=%b expected all 0",
                     en[0], we[0], addr[0], din[0], busy[0], done[0]);
        end else n_pass++;
        rst = 1'b0;
        step();

        // Start a frame and assert reset while it is writing.
        model_clear(0);
        load4(0, 32'hFFFF0000, 32'h0000F800, 32'h07E0001F, 32'hFFFFFFFF, 4);
        pulse_start(0, 32'h100);
        step();
        step();
        step();
        n_total++;
        if (en[0] !== 1'b1) $display("FAIL reset_prewrite: bram_en=%b expected 1", en[0]);
        else n_pass++;
        rst = 1'b1;
        step();
        n_total++;
        if ({en[0], we[0], addr[0], din[0], busy[0], done[0], rd_en[0]} !== 71'h0) begin
            $display("FAIL reset_midframe: en=%b we=%h addr=%h din=%h busy=%b done=%b rd_en=%b expected all 0",
                     en[0], we[0], addr[0], din[0], busy[0], done[0], rd_en[0]);
        end else n_pass++;
        step();
        rst = 1'b0;
        repeat (6) step();
        n_total++;
        if (wcnt[0] !== 1 || done_cnt[0] !== 0 || busy[0] !== 1'b0) begin
            $display("FAIL reset_quiet: writes=%0d done=%0d busy=%b expected 1/0/0",
                     wcnt[0], done_cnt[0], busy[0]);
        end else n_pass++;
    endtask

    task automatic check_p0_frame(input string tag, input logic [31:0] b0);
        logic [31:0] ed[4] = '{32'h00FF0000, 32'h00000055, 32'h00550055, 32'h00FF00FF};
        n_total++;
        if (wcnt[0] !== 4) $display("FAIL %s_count: writes=%0d expected 4", tag, wcnt[0]);
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_total++;
            if (waddr[0][k] !== b0 + 32'(k) || wdata[0][k] !== ed[k]) begin
                $display("FAIL %s_write%0d: got %h@%h expected %h@%h",
                         tag, k, wdata[0][k], waddr[0][k], ed[k], b0 + 32'(k));
            end else n_pass++;
        end
        n_total++;
        if (rd_count[0] !== 4 || we_bad[0] !== 0) begin
            $display("FAIL %s_reads: reads=%0d we_errors=%0d expected 4/0", tag, rd_count[0], we_bad[0]);
        end else n_pass++;
        n_total++;
        if (done_cyc[0] !== wcyc[0][3] + 1) begin
            $display("FAIL %s_done_timing: done cycle %0d expected %0d", tag, done_cyc[0], wcyc[0][3] + 1);
        end else n_pass++;
    endtask

    task automatic test_pack0_average();
        model_clear(0);
        load4(0, 32'hFFFF0000, 32'h0000F800, 32'h07E0001F, 32'hFFFFFFFF, 4);
        pulse_start(0, 32'h100);
        wait_done(0, 50, "p0");
        step();
        n_total++;
        if (busy[0] !== 1'b0) $display("FAIL p0_busy_fall: busy=%b expected 0", busy[0]);
        else n_pass++;
        step();
        check_p0_frame("p0", 32'h100);
        n_total++;
        if (wcyc[0][0] - rcyc[0][0] !== 2) begin
            $display("FAIL p0_latency: write edge - read edge = %0d expected 2", wcyc[0][0] - rcyc[0][0]);
        end else n_pass++;
        n_total++;
        if (done_cnt[0] !== 1) $display("FAIL p0_done_pulses: %0d expected 1", done_cnt[0]);
        else n_pass++;
    endtask

    task automatic test_pack1();
        model_clear(1);
        load4(1, 32'h07E0F800, 32'h001FFFFF, 32'h0, 32'h0, 2);
        pulse_start(1, 32'h40);
        wait_done(1, 50, "p1");
        step();
        step();
        n_total++;
        if (wcnt[1] !== 1 || waddr[1][0] !== 32'h40 || wdata[1][0] !== 32'h55FF5555) begin
            $display("FAIL p1_write: writes=%0d got %h@%h expected 1 write 55ff5555@00000040",
                     wcnt[1], wdata[1][0], waddr[1][0]);
        end else n_pass++;
        n_total++;
        if (wcyc[1][0] - rcyc[1][1] !== 2 || rd_count[1] !== 2) begin
            $display("FAIL p1_latency: latency=%0d reads=%0d expected 2/2",
                     wcyc[1][0] - rcyc[1][1], rd_count[1]);
        end else n_pass++;
        n_total++;
        if (done_cnt[1] !== 1 || busy[1] !== 1'b0) begin
            $display("FAIL p1_done: pulses=%0d busy=%b expected 1/0", done_cnt[1], busy[1]);
        end else n_pass++;
    endtask

    task automatic test_luma();
        logic [31:0] ed[4] = '{32'h0095004C, 32'h00FF00FF, 32'h00000000, 32'h004C004C};
        model_clear(2);
        load4(2, 32'h07E0F800, 32'hFFFFFFFF, 32'h00000000, 32'hF800F800, 4);
        pulse_start(2, 32'h20);
        wait_done(2, 50, "luma");
        step();
        n_total++;
        if (wcnt[2] !== 4) $display("FAIL luma_count: writes=%0d expected 4", wcnt[2]);
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_total++;
            if (waddr[2][k] !== 32'h20 + 32'(k) || wdata[2][k] !== ed[k]) begin
                $display("FAIL luma_write%0d: got %h@%h expected %h@%h",
                         k, wdata[2][k], waddr[2][k], ed[k], 32'h20 + 32'(k));
            end else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        model_clear(0);
        load4(0, 32'hFFFF0000, 32'h0000F800, 32'h07E0001F, 32'hFFFFFFFF, 4);
        rnd[0] = 1'b1;
        pulse_start(0, 32'h100);
        step();
        step();
        pulse_start(0, 32'h300);
        wait_done(0, 300, "stall");
        // Start during the frame_done cycle must be ignored.
        pulse_start(0, 32'h500);
        rnd[0] = 1'b0;
        repeat (10) step();
        check_p0_frame("stall", 32'h100);
        n_total++;
        if (done_cnt[0] !== 1 || busy[0] !== 1'b0) begin
            $display("FAIL stall_no_restart: done=%0d busy=%b expected 1/0", done_cnt[0], busy[0]);
        end else n_pass++;
    endtask

    task automatic test_wrap();
        logic [31:0] ea[4] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        model_clear(0);
        load4(0, 32'hFFFF0000, 32'h0000F800, 32'h07E0001F, 32'hFFFFFFFF, 4);
        pulse_start(0, 32'hFFFFFFFE);
        wait_done(0, 50, "wrap");
        step();
        for (int k = 0; k < 4; k++) begin
            n_total++;
            if (waddr[0][k] !== ea[k]) $display("FAIL wrap_addr%0d: got %h expected %h", k, waddr[0][k], ea[k]);
            else n_pass++;
        end
    endtask

    task automatic test_abort();
        model_clear(1);
        load4(1, 32'h07E0F800, 32'h0, 32'h0, 32'h0, 1);
        pulse_start(1, 32'h80);
        repeat (4) step();
        n_total++;
        if (rd_count[1] !== 1 || busy[1] !== 1'b1) begin
            $display("FAIL abort_pre: reads=%0d busy=%b expected 1/1", rd_count[1], busy[1]);
        end else n_pass++;
        abort_s[1] = 1'b1;
        step();
        abort_s[1] = 1'b0;
        n_total++;
        if (busy[1] !== 1'b0) $display("FAIL abort_busy: busy=%b expected 0", busy[1]);
        else n_pass++;
        repeat (5) step();
        n_total++;
        if (wcnt[1] !== 0 || done_cnt[1] !== 0) begin
            $display("FAIL abort_quiet: writes=%0d done=%0d expected 0/0", wcnt[1], done_cnt[1]);
        end else n_pass++;

        // A clean frame afterwards must not see the discarded half-pair.
        model_clear(1);
        load4(1, 32'h07E0F800, 32'h001FFFFF, 32'h0, 32'h0, 2);
        pulse_start(1, 32'h90);
        wait_done(1, 50, "abort_next");
        step();
        n_total++;
        if (wcnt[1] !== 1 || waddr[1][0] !== 32'h90 || wdata[1][0] !== 32'h55FF5555) begin
            $display("FAIL abort_next_write: writes=%0d got %h@%h expected 1 write 55ff5555@00000090",
                     wcnt[1], wdata[1][0], waddr[1][0]);
        end else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            start[i] = 1'b0;
            abort_s[i] = 1'b0;
            base[i] = 32'h0;
            dout[i] = 32'h0;
            rd_smp[i] = 1'b0;
            fmem[i] = '{default: 32'h0};
            model_clear(i);
        end
        test_reset();
        test_pack0_average();
        test_pack1();
        test_luma();
        test_back_to_back();
        test_wrap();
        test_abort();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
